ex_hazard_scheduler: RTL and testbench

Pipeline controller that sequences the execute stage: tracks the destination registers of in-flight instructions in EX, MEM and WB, drives the ALU source-select muxes for operand forwarding, and schedules stalls (load-use, memory wait) and flushes (taken branch). It sits beside the ID/EX, EX/MEM and MEM/WB pipeline registers, taking decode-side fields from ID and status from EX/MEM, and feeding freeze/flush to IF/ID/ID-EX and the select lines to the EX stage.

---
 rtl/ex_hazard_scheduler.sv | 121 ++++++++++++
 tb/tb_ex_hazard_scheduler.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/ex_hazard_scheduler.sv
// ex_hazard_scheduler: EX/MEM/WB destination tracking, operand-forward selects,
// load-use / memory-wait stalls and taken-branch flush.  Rev 1.0
`default_nettype none

module ex_hazard_scheduler #(
  parameter bit FWD_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [3:0] id_src1,
  input  logic [3:0] id_src2,
  input  logic       id_two_src,
  input  logic       id_wb_en,
  input  logic       id_mem_r_en,
  input  logic [3:0] id_dest,
  input  logic       branch_taken,
  input  logic       mem_stall,
  output logic       freeze,
  output logic       flush,
  output logic [1:0] sel_src1,
  output logic [1:0] sel_src2
);

  typedef struct packed {
    logic       valid;
    logic       wb_en;
    logic       mem_r_en;
    logic [3:0] dest;
    logic [3:0] src1;
    logic [3:0] src2;
    logic       two_src;
  } ex_slot_t;

  typedef struct packed {
    logic       valid;
    logic       wb_en;
    logic       mem_r_en;
    logic [3:0] dest;
  } mem_slot_t;

  ex_slot_t  ex_q;
  ex_slot_t  id_slot;
  mem_slot_t mem_q;
  logic       wb_valid;
  logic       wb_wb_en;
  logic [3:0] wb_dest;

  logic hz1;
  logic hz2;
  logic hazard;
  logic flush_raw;
  logic issue;

  function automatic logic match(input logic v, input logic we,
                                 input logic [3:0] d, input logic [3:0] r);
    return v & we & (d == r);
  endfunction

  assign id_slot = '{valid: 1'b1, wb_en: id_wb_en, mem_r_en: id_mem_r_en,
                     dest: id_dest, src1: id_src1, src2: id_src2,
                     two_src: id_two_src};

  always_comb begin
    hz1 = 1'b0;
    hz2 = 1'b0;
    if (FWD_EN) begin
      hz1 = match(ex_q.valid, ex_q.wb_en, ex_q.dest, id_src1) & ex_q.mem_r_en;
      hz2 = match(ex_q.valid, ex_q.wb_en, ex_q.dest, id_src2) & ex_q.mem_r_en;
    end else begin
      hz1 = match(ex_q.valid, ex_q.wb_en, ex_q.dest, id_src1) |
            match(mem_q.valid, mem_q.wb_en, mem_q.dest, id_src1);
      hz2 = match(ex_q.valid, ex_q.wb_en, ex_q.dest, id_src2) |
            match(mem_q.valid, mem_q.wb_en, mem_q.dest, id_src2);
    end
    hazard    = id_valid & (hz1 | (id_two_src & hz2));
    flush_raw = branch_taken & ex_q.valid & ~mem_stall;
    issue     = id_valid & ~hazard & ~flush_raw & ~mem_stall;
  end

  // Outputs forced low while reset is held so a pending stall/flush never leaks out.
  assign flush  = flush_raw & ~rst;
  assign freeze = ~rst & (mem_stall | (hazard & ~flush_raw));

  always_comb begin
    sel_src1 = 2'b00;
    sel_src2 = 2'b00;
    if (FWD_EN && ex_q.valid) begin
      if (match(mem_q.valid, mem_q.wb_en, mem_q.dest, ex_q.src1) & ~mem_q.mem_r_en)
        sel_src1 = 2'b10;
      else if (match(wb_valid, wb_wb_en, wb_dest, ex_q.src1))
        sel_src1 = 2'b01;
      if (ex_q.two_src) begin
        if (match(mem_q.valid, mem_q.wb_en, mem_q.dest, ex_q.src2) & ~mem_q.mem_r_en)
          sel_src2 = 2'b10;
        else if (match(wb_valid, wb_wb_en, wb_dest, ex_q.src2))
          sel_src2 = 2'b01;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q     <= '0;
      mem_q    <= '0;
      wb_valid <= 1'b0;
      wb_wb_en <= 1'b0;
      wb_dest  <= 4'd0;
    end else if (!mem_stall) begin
      wb_valid <= mem_q.valid;
      wb_wb_en <= mem_q.wb_en;
      wb_dest  <= mem_q.dest;
      mem_q    <= '{valid: ex_q.valid, wb_en: ex_q.wb_en,
                    mem_r_en: ex_q.mem_r_en, dest: ex_q.dest};
      ex_q     <= issue ? id_slot : '0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ex_hazard_scheduler.sv
// tb_ex_hazard_scheduler: scoreboard bench for ex_hazard_scheduler (FWD_EN=1 and FWD_EN=0).  Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_ex_hazard_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 1'b0;
  logic [3:0] id_src1 = 4'd0;
  logic [3:0] id_src2 = 4'd0;
  logic       id_two_src = 1'b0;
  logic       id_wb_en = 1'b0;
  logic       id_mem_r_en = 1'b0;
  logic [3:0] id_dest = 4'd0;
  logic       branch_taken = 1'b0;
  logic       mem_stall = 1'b0;

  logic       freeze, flush, freeze_nf, flush_nf;
  logic [1:0] sel_src1, sel_src2, sel_src1_nf, sel_src2_nf;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic       nf;
    logic [5:0] exp;
    logic [7:0] id;
  } sb_t;
  sb_t sb_q[$];
  int  n_push = 0;

  ex_hazard_scheduler #(.FWD_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_two_src(id_two_src), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
    .id_dest(id_dest), .branch_taken(branch_taken), .mem_stall(mem_stall),
    .freeze(freeze), .flush(flush), .sel_src1(sel_src1), .sel_src2(sel_src2)
  );

  ex_hazard_scheduler #(.FWD_EN(1'b0)) dut_nf (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_two_src(id_two_src), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
    .id_dest(id_dest), .branch_taken(branch_taken), .mem_stall(mem_stall),
    .freeze(freeze_nf), .flush(flush_nf), .sel_src1(sel_src1_nf), .sel_src2(sel_src2_nf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got {frz,fl,s1,s2}=%b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one ID/status cycle and queue the outputs expected during that cycle.
  task automatic drive(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                       input logic two, input logic we, input logic ld,
                       input logic [3:0] d, input logic br, input logic ms,
                       input logic nf, input logic [5:0] exp);
    @(negedge clk);
    id_valid = v; id_src1 = s1; id_src2 = s2; id_two_src = two;
    id_wb_en = we; id_mem_r_en = ld; id_dest = d;
    branch_taken = br; mem_stall = ms;
    sb_q.push_back('{nf: nf, exp: exp, id: n_push[7:0]});
    n_push++;
  endtask

  task automatic idle(input logic nf, input logic [5:0] exp);
    drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, nf, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    id_valid = 1'b0; branch_taken = 1'b0; mem_stall = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin : monitor
    sb_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        if (e.nf)
          check($sformatf("sb_nf%0d", e.id), {freeze_nf, flush_nf, sel_src1_nf, sel_src2_nf}, e.exp);
        else
          check($sformatf("sb%0d", e.id), {freeze, flush, sel_src1, sel_src2}, e.exp);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: bench did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin : stim
    #1;
    check("reset_fwd", {freeze, flush, sel_src1, sel_src2}, 6'b000000);
    check("reset_nf", {freeze_nf, flush_nf, sel_src1_nf, sel_src2_nf}, 6'b000000);
    @(negedge clk);
    rst = 1'b0;

    // ALU chain: MEM forward then WB forward
    drive(1, 4'd2, 4'd3, 1, 1, 0, 4'd1, 0, 0, 0, 6'b000000);
    drive(1, 4'd1, 4'd3, 1, 1, 0, 4'd2, 0, 0, 0, 6'b000000);
    drive(1, 4'd1, 4'd8, 1, 1, 0, 4'd7, 0, 0, 0, 6'b001000);
    idle(0, 6'b000100);
    idle(0, 6'b000000);

    // Load-use: one bubble then WB forward on both operands
    do_reset();
    drive(1, 4'd9, 4'd0, 0, 1, 1, 4'd4, 0, 0, 0, 6'b000000);
    drive(1, 4'd4, 4'd4, 1, 1, 0, 4'd5, 0, 0, 0, 6'b100000);
    drive(1, 4'd4, 4'd4, 1, 1, 0, 4'd5, 0, 0, 0, 6'b000000);
    idle(0, 6'b000101);
    idle(0, 6'b000000);

    // Taken branch beats a load-use hazard; branch_taken with empty EX is ignored
    do_reset();
    drive(1, 4'd9, 4'd0, 0, 1, 1, 4'd4, 0, 0, 0, 6'b000000);
    drive(1, 4'd4, 4'd0, 0, 1, 0, 4'd5, 1, 0, 0, 6'b010000);
    drive(0, 4'd0, 4'd0, 0, 0, 0, 4'd0, 1, 0, 0, 6'b000000);

    // Memory wait with branch in EX: slots hold, flush deferred
    do_reset();
    drive(1, 4'd2, 4'd3, 1, 1, 0, 4'd1, 0, 0, 0, 6'b000000);
    drive(1, 4'd1, 4'd0, 0, 0, 0, 4'd0, 0, 0, 0, 6'b000000);
    for (int i = 0; i < 3; i++)
      drive(1, 4'd1, 4'd0, 0, 1, 0, 4'd6, 1, 1, 0, 6'b101000);
    drive(1, 4'd1, 4'd0, 0, 1, 0, 4'd6, 1, 0, 0, 6'b011000);
    idle(0, 6'b000000);

    // Forwarding disabled: two stall cycles, selects stay at regfile
    do_reset();
    drive(1, 4'd2, 4'd3, 1, 1, 0, 4'd1, 0, 0, 1, 6'b000000);
    drive(1, 4'd1, 4'd0, 0, 1, 0, 4'd6, 0, 0, 1, 6'b100000);
    drive(1, 4'd1, 4'd0, 0, 1, 0, 4'd6, 0, 0, 1, 6'b100000);
    drive(1, 4'd1, 4'd0, 0, 1, 0, 4'd6, 0, 0, 1, 6'b000000);
    idle(1, 6'b000000);

    // Asynchronous reset in the middle of a stall
    do_reset();
    drive(1, 4'd2, 4'd3, 1, 1, 0, 4'd1, 0, 0, 0, 6'b000000);
    drive(1, 4'd1, 4'd0, 0, 1, 1, 4'd4, 0, 0, 0, 6'b000000);
    drive(1, 4'd4, 4'd0, 0, 1, 0, 4'd5, 0, 1, 0, 6'b101000);
    #3;
    rst = 1'b1;
    #1;
    check("rst_async", {freeze, flush, sel_src1, sel_src2}, 6'b000000);
    @(negedge clk);
    rst = 1'b0;
    drive(1, 4'd4, 4'd0, 0, 1, 0, 4'd5, 0, 0, 0, 6'b000000);
    idle(0, 6'b000000);

    @(negedge clk);
    @(negedge clk);
    check("sb_drained", 6'(sb_q.size()), 6'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
